// File: rtl/led_seq_pkg.sv
// Shared opcodes and mode encodings for the LED pattern sequencer.
package led_seq_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOP      = 3'd0;
   localparam logic [OP_W-1:0] OP_RUN_FWD  = 3'd1;
   localparam logic [OP_W-1:0] OP_RUN_REV  = 3'd2;
   localparam logic [OP_W-1:0] OP_RUN_PING = 3'd3;
   localparam logic [OP_W-1:0] OP_PAUSE    = 3'd4;
   localparam logic [OP_W-1:0] OP_STEP     = 3'd5;
   localparam logic [OP_W-1:0] OP_GOTO     = 3'd6;
   localparam logic [OP_W-1:0] OP_SET_DIV  = 3'd7;

   typedef enum logic [1:0] {
      MODE_PAUSED = 2'd0,
      MODE_FWD    = 2'd1,
      MODE_REV    = 2'd2,
      MODE_PING   = 2'd3
   } mode_e;

endpackage

// File: rtl/led_seq_prescaler.sv
// Loadable down-counter producing a one-cycle tick every load_val+1 cycles.
module led_seq_prescaler
   import led_seq_pkg::*;
#(
   parameter int                   DIV_WIDTH = 25,
   parameter logic [DIV_WIDTH-1:0] RESET_VAL = '1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 hold_i,
   input  logic                 load_i,
   input  logic [DIV_WIDTH-1:0] load_val_i,
   output logic                 tick_o
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;

   // A load or hold in the terminal-count cycle swallows the tick.
   always_comb begin
      tick_o = (cnt_q == '0) && !hold_i && !load_i;
      if (load_i || hold_i || (cnt_q == '0)) begin
         cnt_d = load_val_i;
      end else begin
         cnt_d = cnt_q - DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= RESET_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern ROM sequencer: command-driven mode/step FSM plus ROM address register.
//
//  state        | meaning
//  MODE_PAUSED  | no advance; a STEP sets step_pend and advances once on the next tick
//  MODE_FWD     | +1 per tick, last entry wraps to 0
//  MODE_REV     | -1 per tick, 0 wraps to last entry
//  MODE_PING    | bounce between 0 and last entry, direction in ping_up
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int          NUM_PATTERNS = 10,
   parameter int          AWIDTH       = 4,
   parameter int          DIV_WIDTH    = 25,
   parameter int unsigned DEFAULT_DIV  = 32'h01FF_FFFF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [OP_W-1:0]      cmd_op_i,
   input  logic [DIV_WIDTH-1:0] cmd_arg_i,
   output logic [AWIDTH-1:0]    raddr_o,
   output logic                 rd_en_o,
   output logic                 wrap_o,
   output logic [1:0]           mode_o
);

   localparam logic [AWIDTH-1:0]    LAST     = AWIDTH'(NUM_PATTERNS - 1);
   localparam logic [DIV_WIDTH-1:0] LAST_ARG = DIV_WIDTH'(NUM_PATTERNS - 1);
   localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);

   mode_e                mode_q, mode_d;
   mode_e                last_q, last_d;
   mode_e                adv_mode;
   logic                 ping_up_q, ping_up_d;
   logic                 step_q, step_d;
   logic [AWIDTH-1:0]    raddr_q, raddr_d, nxt_addr;
   logic                 rd_en_q, rd_en_d;
   logic                 wrap_q, wrap_d;
   logic [DIV_WIDTH-1:0] reload_q, reload_d;
   logic                 accept;
   logic                 goto_hit;
   logic                 do_adv;
   logic                 pre_hold;
   logic                 pre_load;
   logic [DIV_WIDTH-1:0] pre_load_val;
   logic                 tick;

   assign cmd_ready_o = !step_q;
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign pre_hold    = (mode_q == MODE_PAUSED) && !step_q;

   led_seq_prescaler #(
      .DIV_WIDTH (DIV_WIDTH),
      .RESET_VAL (DIV_RST)
   ) u_prescaler (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .hold_i     (pre_hold),
      .load_i     (pre_load),
      .load_val_i (pre_load_val),
      .tick_o     (tick)
   );

   always_comb begin
      mode_d       = mode_q;
      last_d       = last_q;
      ping_up_d    = ping_up_q;
      step_d       = step_q;
      raddr_d      = raddr_q;
      rd_en_d      = 1'b0;
      wrap_d       = 1'b0;
      reload_d     = reload_q;
      pre_load     = 1'b0;
      pre_load_val = reload_q;
      goto_hit     = 1'b0;
      do_adv       = 1'b0;
      adv_mode     = mode_q;
      nxt_addr     = raddr_q;

      if (accept) begin
         case (cmd_op_i)
            OP_RUN_FWD: begin
               mode_d = MODE_FWD;
               last_d = MODE_FWD;
            end
            OP_RUN_REV: begin
               mode_d = MODE_REV;
               last_d = MODE_REV;
            end
            OP_RUN_PING: begin
               mode_d    = MODE_PING;
               last_d    = MODE_PING;
               ping_up_d = 1'b1;
            end
            OP_PAUSE: mode_d = MODE_PAUSED;
            OP_STEP: begin
               if (mode_q == MODE_PAUSED) begin
                  step_d   = 1'b1;
                  pre_load = 1'b1;
               end
            end
            OP_GOTO: begin
               raddr_d  = (cmd_arg_i > LAST_ARG) ? LAST : cmd_arg_i[AWIDTH-1:0];
               rd_en_d  = 1'b1;
               pre_load = 1'b1;
               goto_hit = 1'b1;
            end
            OP_SET_DIV: begin
               reload_d     = cmd_arg_i;
               pre_load     = 1'b1;
               pre_load_val = cmd_arg_i;
            end
            default: ;
         endcase
      end

      // A coincident tick follows the newly accepted mode, so PAUSE suppresses it.
      if (tick && !goto_hit) begin
         if (step_q) begin
            do_adv   = 1'b1;
            adv_mode = last_q;
            step_d   = 1'b0;
         end else if (mode_d != MODE_PAUSED) begin
            do_adv   = 1'b1;
            adv_mode = mode_d;
         end
      end

      if (do_adv) begin
         case (adv_mode)
            MODE_FWD: begin
               if (raddr_q == LAST) begin
                  nxt_addr = '0;
                  wrap_d   = 1'b1;
               end else begin
                  nxt_addr = raddr_q + AWIDTH'(1);
               end
            end
            MODE_REV: begin
               if (raddr_q == '0) begin
                  nxt_addr = LAST;
                  wrap_d   = 1'b1;
               end else begin
                  nxt_addr = raddr_q - AWIDTH'(1);
               end
            end
            MODE_PING: begin
               if (NUM_PATTERNS == 1) begin
                  wrap_d = 1'b1;
               end else if (ping_up_d) begin
                  if (raddr_q == LAST) begin
                     ping_up_d = 1'b0;
                     nxt_addr  = raddr_q - AWIDTH'(1);
                     wrap_d    = 1'b1;
                  end else begin
                     nxt_addr = raddr_q + AWIDTH'(1);
                  end
               end else begin
                  if (raddr_q == '0) begin
                     ping_up_d = 1'b1;
                     nxt_addr  = raddr_q + AWIDTH'(1);
                     wrap_d    = 1'b1;
                  end else begin
                     nxt_addr = raddr_q - AWIDTH'(1);
                  end
               end
            end
            default: ;
         endcase
         raddr_d = nxt_addr;
         rd_en_d = (nxt_addr != raddr_q);
      end
   end

   // rd_en resets high so the ROM fetches entry 0 in the first cycle out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q    <= MODE_FWD;
         last_q    <= MODE_FWD;
         ping_up_q <= 1'b1;
         step_q    <= 1'b0;
         raddr_q   <= '0;
         rd_en_q   <= 1'b1;
         wrap_q    <= 1'b0;
         reload_q  <= DIV_RST;
      end else begin
         mode_q    <= mode_d;
         last_q    <= last_d;
         ping_up_q <= ping_up_d;
         step_q    <= step_d;
         raddr_q   <= raddr_d;
         rd_en_q   <= rd_en_d;
         wrap_q    <= wrap_d;
         reload_q  <= reload_d;
      end
   end

   assign raddr_o = raddr_q;
   assign rd_en_o = rd_en_q;
   assign wrap_o  = wrap_q;
   assign mode_o  = mode_q;

endmodule
